// File: rtl/udma_mdio_pkg.sv
// Shared definitions for the uDMA MDIO master: register map, FSM states,
// Clause 22/45 frame constants and field widths.
package udma_mdio_pkg;

    localparam int PHY_W   = 5;
    localparam int REG_W   = 5;
    localparam int DATA_W  = 16;
    localparam int FRAME_W = 64;
    localparam int CNT_W   = 6;

    localparam logic [4:0] REG_CTRL    = 5'd0;
    localparam logic [4:0] REG_STATUS  = 5'd1;
    localparam logic [4:0] REG_PHY     = 5'd2;
    localparam logic [4:0] REG_REG     = 5'd3;
    localparam logic [4:0] REG_TX      = 5'd4;
    localparam logic [4:0] REG_RX      = 5'd5;
    localparam logic [4:0] REG_CLKDIV  = 5'd6;
    localparam logic [4:0] REG_IRQ_EN  = 5'd7;

    // Index of the last bit of each frame section.
    localparam logic [CNT_W-1:0] LAST_PRE  = 6'd31;
    localparam logic [CNT_W-1:0] LAST_HDR  = 6'd45;
    localparam logic [CNT_W-1:0] LAST_TA   = 6'd47;
    localparam logic [CNT_W-1:0] LAST_DATA = 6'd63;

    localparam logic [1:0] ST_C22   = 2'b01;
    localparam logic [1:0] ST_C45   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] TA_DRIVE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA
    } state_e;

endpackage

// File: rtl/udma_mdio_clkgen.sv
// MDC generator: toggles the MDC level every CLKDIV+1 cycles while enabled
// and flags the cycle before each rising/falling MDC edge.
module udma_mdio_clkgen #(
    parameter int CLKDIV_W = 8
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                en_i,
    input  logic [CLKDIV_W-1:0] clkdiv_i,
    output logic                mdc_o,
    output logic                rise_o,
    output logic                fall_o
);

    logic [CLKDIV_W-1:0] cnt;
    logic                tick;

    assign tick   = en_i && (cnt == clkdiv_i);
    assign rise_o = tick && !mdc_o;
    assign fall_o = tick && mdc_o;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt   <= '0;
            mdc_o <= 1'b0;
        end else if (!en_i) begin
            cnt   <= '0;
            mdc_o <= 1'b0;
        end else if (tick) begin
            cnt   <= '0;
            mdc_o <= ~mdc_o;
        end else begin
            cnt   <= cnt + CLKDIV_W'(1);
        end
    end

endmodule

// File: rtl/udma_mdio_master.sv
// MDIO/SMI management master on the uDMA cfg port, N_BUS MDC/MDIO buses.
// Optional Clause 45 framing is enabled by defining MDIO_CLAUSE45_EN.
module udma_mdio_master
    import udma_mdio_pkg::*;
#(
    parameter int N_BUS    = 2,
    parameter int CLKDIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [31:0]      cfg_data_i,
    input  logic [4:0]       cfg_addr_i,
    input  logic             cfg_valid_i,
    input  logic             cfg_rwn_i,
    output logic [31:0]      cfg_data_o,
    output logic             cfg_ready_o,
    output logic [N_BUS-1:0] mdc_o,
    output logic             mdio_o,
    output logic [N_BUS-1:0] mdio_oe_o,
    input  logic [N_BUS-1:0] mdio_i,
    output logic             irq_o
);

    localparam logic [2:0] N_BUS_L = 3'(N_BUS);

    state_e               state, state_next;
    logic [CNT_W-1:0]     bit_cnt;
    logic [PHY_W-1:0]     phy_addr;
    logic [REG_W-1:0]     reg_addr;
    logic [DATA_W-1:0]    tx_data, rx_data, rx_shift;
    logic [CLKDIV_W-1:0]  clkdiv;
    logic                 irq_en, ctrl_rw, done, err;
    logic [1:0]           ctrl_bus, bus_sel, new_bus;
    logic [FRAME_W-1:0]   frame_sr, new_frame;
    logic                 frame_drive, new_drive;
    logic                 mdc, rise, fall, busy, oe, mdio_in;
    logic                 wr, status_rd, start_req, start_ok, frame_end;
    logic [1:0]           st, op;
    logic                 unused_bits;
`ifdef MDIO_CLAUSE45_EN
    logic [1:0]           ctrl_c45op;
    logic                 ctrl_c45en;
`endif

    assign cfg_ready_o = 1'b1;
    assign unused_bits = ^cfg_data_i[31:16];

    assign wr        = cfg_valid_i && !cfg_rwn_i;
    assign status_rd = cfg_valid_i && cfg_rwn_i && (cfg_addr_i == REG_STATUS);
    assign start_req = wr && (cfg_addr_i == REG_CTRL) && cfg_data_i[0];
    assign busy      = (state != S_IDLE);
    assign start_ok  = start_req && !busy;
    assign frame_end = (state == S_DATA) && fall && (bit_cnt == LAST_DATA);
    assign new_bus   = ({1'b0, cfg_data_i[9:8]} < N_BUS_L) ? cfg_data_i[9:8] : 2'd0;

    udma_mdio_clkgen #(.CLKDIV_W(CLKDIV_W)) u_clkgen (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .en_i     (busy),
        .clkdiv_i (clkdiv),
        .mdc_o    (mdc),
        .rise_o   (rise),
        .fall_o   (fall)
    );

    // Frame image assembled from the CTRL write that starts it.
    always_comb begin
        st        = ST_C22;
        op        = cfg_data_i[1] ? OP_WRITE : OP_READ;
        new_drive = cfg_data_i[1];
`ifdef MDIO_CLAUSE45_EN
        if (cfg_data_i[3:2] != 2'b00 || cfg_data_i[4]) begin
            st        = ST_C45;
            op        = cfg_data_i[3:2];
            new_drive = !cfg_data_i[3];
        end
`endif
        new_frame = {32'hFFFF_FFFF, st, op, phy_addr, reg_addr,
                     new_drive ? TA_DRIVE : 2'b00,
                     new_drive ? tx_data : 16'h0000};
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            phy_addr <= '0;
            reg_addr <= '0;
            tx_data  <= '0;
            clkdiv   <= '0;
            irq_en   <= 1'b0;
            ctrl_rw  <= 1'b0;
            ctrl_bus <= '0;
`ifdef MDIO_CLAUSE45_EN
            ctrl_c45op <= '0;
            ctrl_c45en <= 1'b0;
`endif
        end else if (wr) begin
            case (cfg_addr_i)
                REG_CTRL: begin
                    ctrl_rw  <= cfg_data_i[1];
                    ctrl_bus <= cfg_data_i[9:8];
`ifdef MDIO_CLAUSE45_EN
                    ctrl_c45op <= cfg_data_i[3:2];
                    ctrl_c45en <= cfg_data_i[4];
`endif
                end
                REG_PHY:    phy_addr <= cfg_data_i[PHY_W-1:0];
                REG_REG:    reg_addr <= cfg_data_i[REG_W-1:0];
                REG_TX:     tx_data  <= cfg_data_i[DATA_W-1:0];
                REG_CLKDIV: clkdiv   <= cfg_data_i[CLKDIV_W-1:0];
                REG_IRQ_EN: irq_en   <= cfg_data_i[0];
                default: ;
            endcase
        end
    end

    // Sticky status: a set in the same cycle as the clearing read wins.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            done  <= 1'b0;
            err   <= 1'b0;
            irq_o <= 1'b0;
        end else begin
            done  <= frame_end || (done && !status_rd);
            err   <= (start_req && busy) || (err && !status_rd);
            irq_o <= frame_end && irq_en;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start_ok)                         state_next = S_PRE;
            S_PRE:  if (fall && bit_cnt == LAST_PRE)      state_next = S_HDR;
            S_HDR:  if (fall && bit_cnt == LAST_HDR)      state_next = S_TA;
            S_TA:   if (fall && bit_cnt == LAST_TA)       state_next = S_DATA;
            S_DATA: if (frame_end)                        state_next = S_IDLE;
            default:                                      state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            frame_sr    <= '0;
            frame_drive <= 1'b0;
            bus_sel     <= '0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
        end else if (start_ok) begin
            frame_sr    <= new_frame;
            frame_drive <= new_drive;
            bus_sel     <= new_bus;
            bit_cnt     <= '0;
            rx_shift    <= '0;
        end else if (busy) begin
            if (fall) begin
                frame_sr <= {frame_sr[FRAME_W-2:0], 1'b0};
                bit_cnt  <= bit_cnt + 6'd1;
            end
            if (rise && state == S_DATA) begin
                rx_shift <= {rx_shift[DATA_W-2:0], mdio_in};
            end
            if (frame_end && !frame_drive) begin
                rx_data <= rx_shift;
            end
        end
    end

    always_comb begin
        mdio_in = 1'b0;
        for (int i = 0; i < N_BUS; i++) begin
            if (bus_sel == 2'(i)) mdio_in = mdio_i[i];
        end
    end

    // NOTE: every combinational output gets a default first so no latch
    // is inferred for the buses that are not selected.
    always_comb begin
        mdc_o     = '0;
        mdio_oe_o = '0;
        oe        = busy && (frame_drive || state == S_PRE || state == S_HDR);
        for (int i = 0; i < N_BUS; i++) begin
            if (bus_sel == 2'(i)) begin
                mdc_o[i]     = mdc;
                mdio_oe_o[i] = oe;
            end
        end
        mdio_o = oe && frame_sr[FRAME_W-1];
    end

    always_comb begin
        cfg_data_o = '0;
        case (cfg_addr_i)
            REG_CTRL: begin
                cfg_data_o[9:8] = ctrl_bus;
                cfg_data_o[1]   = ctrl_rw;
`ifdef MDIO_CLAUSE45_EN
                cfg_data_o[3:2] = ctrl_c45op;
                cfg_data_o[4]   = ctrl_c45en;
`endif
            end
            REG_STATUS: cfg_data_o[2:0]          = {err, done, busy};
            REG_PHY:    cfg_data_o[PHY_W-1:0]    = phy_addr;
            REG_REG:    cfg_data_o[REG_W-1:0]    = reg_addr;
            REG_TX:     cfg_data_o[DATA_W-1:0]   = tx_data;
            REG_RX:     cfg_data_o[DATA_W-1:0]   = rx_data;
            REG_CLKDIV: cfg_data_o[CLKDIV_W-1:0] = clkdiv;
            REG_IRQ_EN: cfg_data_o[0]            = irq_en;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_udma_mdio_master.sv
// Scoreboard bench for udma_mdio_master: expected frames are queued at start
// and compared against the MDC/MDIO activity when each frame completes.
module tb_udma_mdio_master;

    localparam int N_BUS    = 2;
    localparam int CLKDIV_W = 8;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [31:0]      cfg_wdata = '0;
    logic [4:0]       cfg_addr = '0;
    logic             cfg_valid = 1'b0;
    logic             cfg_rwn = 1'b0;
    logic [31:0]      cfg_rdata;
    logic             cfg_ready;
    logic [N_BUS-1:0] mdc, mdio_oe;
    logic [N_BUS-1:0] mdio_in = '0;
    logic             mdio_out, irq;

    udma_mdio_master #(.N_BUS(N_BUS), .CLKDIV_W(CLKDIV_W)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .cfg_data_i  (cfg_wdata),
        .cfg_addr_i  (cfg_addr),
        .cfg_valid_i (cfg_valid),
        .cfg_rwn_i   (cfg_rwn),
        .cfg_data_o  (cfg_rdata),
        .cfg_ready_o (cfg_ready),
        .mdc_o       (mdc),
        .mdio_o      (mdio_out),
        .mdio_oe_o   (mdio_oe),
        .mdio_i      (mdio_in),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] bits;
        logic [63:0] mask;
        int          len;
        int          start;
        logic        irq_exp;
    } frame_t;

    frame_t sb_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] c22_frame(input logic rw, input logic [4:0] phy,
                                              input logic [4:0] ra, input logic [15:0] d);
        return {32'hFFFF_FFFF, 2'b01, rw ? 2'b01 : 2'b10, phy, ra,
                rw ? 2'b10 : 2'b00, rw ? d : 16'h0000};
    endfunction

    function automatic logic [63:0] oe_mask(input logic rw);
        return rw ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFC_0000;
    endfunction

    // Bus monitor and PHY model, sampling away from the active edge.
    int          mon_bus = 0;
    logic        phy_read = 1'b0;
    logic [15:0] phy_data = '0;
    logic        prev_mdc = 1'b0;
    logic        cur_mdc;
    int          nbits = 0;
    int          frames_done = 0;
    int          irq_cnt = 0;
    logic [63:0] cap = '0, oe_cap = '0;
    logic        stray = 1'b0;
    logic [N_BUS-1:0] sel_mask;
    frame_t      mon_f;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_mdc = 1'b0;
            nbits    = 0;
            cap      = '0;
            oe_cap   = '0;
            stray    = 1'b0;
            mdio_in  = '0;
        end else begin
            if (irq) irq_cnt++;
            sel_mask = N_BUS'(1) << mon_bus;
            if (((mdc | mdio_oe) & ~sel_mask) != '0) stray = 1'b1;
            cur_mdc = mdc[mon_bus];
            if (cur_mdc && !prev_mdc) begin
                cap    = {cap[62:0], mdio_out};
                oe_cap = {oe_cap[62:0], mdio_oe[mon_bus]};
                nbits++;
            end
            if (!cur_mdc && prev_mdc) begin
                if (nbits == 64) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        mon_f = sb_q.pop_front();
                        check("frame_bits", cap & mon_f.mask, mon_f.bits & mon_f.mask);
                        check("frame_oe", oe_cap, mon_f.mask);
                        check("frame_cycles", 64'(cyc - mon_f.start), 64'(mon_f.len));
                        check("irq_at_end", irq, mon_f.irq_exp);
                        check("idle_bus_quiet", stray, 0);
                    end
                    frames_done++;
                    nbits   = 0;
                    stray   = 1'b0;
                    mdio_in = '0;
                end else if (phy_read && nbits >= 48) begin
                    mdio_in = phy_data[63-nbits] ? sel_mask : '0;
                end else begin
                    mdio_in = '0;
                end
            end
            prev_mdc = cur_mdc;
        end
    end

    task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_addr  = a;
        cfg_wdata = d;
        cfg_rwn   = 1'b0;
        cfg_valid = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic cfg_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        cfg_addr  = a;
        cfg_rwn   = 1'b1;
        cfg_valid = 1'b1;
        #1;
        d = cfg_rdata;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        cfg_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic start_frame(input logic [31:0] ctrl, input logic [63:0] bits,
                               input logic [63:0] mask, input int len, input logic irq_exp);
        frame_t f;
        cfg_write(5'd0, ctrl);
        f.bits    = bits;
        f.mask    = mask;
        f.len     = len;
        f.start   = cyc;
        f.irq_exp = irq_exp;
        sb_q.push_back(f);
    endtask

    task automatic wait_frames(input int n);
        int budget = 0;
        while (frames_done < n && budget < 3000) begin
            @(posedge clk);
            budget++;
        end
        check("frame_completes", 64'(frames_done >= n), 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {mdc, mdio_oe, mdio_out, irq}, '0);
    endtask

    initial begin
        logic [31:0] d;
        int budget;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset_outputs");
        rstn = 1'b1;
        check("cfg_ready", cfg_ready, 1);

        // Reset asserted while idle clears every register.
        cfg_write(5'd2, 32'h5);
        cfg_write(5'd6, 32'h3);
        cfg_write(5'd7, 32'h1);
        cfg_write(5'd4, 32'h1111);
        cfg_write(5'd0, 32'h102);
        @(negedge clk);
        #2 rstn = 1'b0;
        #3 check_outputs_zero("idle_reset_outputs");
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cfg_read(5'(i), d);
            check($sformatf("reg%0d_after_reset", i), d, 0);
        end

        // Clause 22 write, CLKDIV=1, TX_DATA overwritten mid-frame.
        cfg_write(5'd6, 32'h1);
        cfg_write(5'd2, 32'h03);
        cfg_write(5'd3, 32'h01);
        cfg_write(5'd4, 32'hA5A5);
        cfg_write(5'd7, 32'h1);
        mon_bus = 0;
        start_frame(32'h3, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'b00011, 5'b00001, 2'b10, 16'hA5A5},
                    64'hFFFF_FFFF_FFFF_FFFF, 256, 1'b1);
        repeat (40) @(posedge clk);
        cfg_write(5'd4, 32'hFFFF);
        wait_frames(1);
        read_check("status_after_write", 5'd1, 32'h2);
        read_check("status_cleared", 5'd1, 32'h0);
        read_check("rx_untouched_by_write", 5'd5, 32'h0);

        // Clause 22 read on bus 1.
        cfg_write(5'd2, 32'h07);
        cfg_write(5'd3, 32'h02);
        mon_bus  = 1;
        phy_read = 1'b1;
        phy_data = 16'h1234;
        start_frame(32'h101, c22_frame(1'b0, 5'h07, 5'h02, 16'h0), oe_mask(1'b0), 256, 1'b1);
        wait_frames(2);
        phy_read = 1'b0;
        read_check("rx_bus1", 5'd5, 32'h1234);

        // Second start mid-frame: err sets, bitstream unchanged.
        mon_bus = 0;
        cfg_write(5'd2, 32'h1F);
        cfg_write(5'd3, 32'h1E);
        cfg_write(5'd4, 32'h5A3C);
        start_frame(32'h3, c22_frame(1'b1, 5'h1F, 5'h1E, 16'h5A3C), oe_mask(1'b1), 256, 1'b1);
        repeat (60) @(posedge clk);
        cfg_write(5'd0, 32'h103);
        read_check("status_busy_done_err", 5'd1, 32'h7);
        read_check("status_err_cleared", 5'd1, 32'h1);
        wait_frames(3);
        read_check("status_after_busy_start", 5'd1, 32'h2);

        // Reset during DATA of a read frame aborts it.
        cfg_write(5'd6, 32'h0);
        phy_read = 1'b1;
        phy_data = 16'hBEEF;
        start_frame(32'h1, c22_frame(1'b0, 5'h1F, 5'h1E, 16'h0), oe_mask(1'b0), 128, 1'b1);
        budget = 0;
        while (nbits < 52 && budget < 1000) begin
            @(posedge clk);
            budget++;
        end
        check("reached_data_phase", 64'(nbits >= 52), 1);
        @(posedge clk);
        #2 rstn = 1'b0;
        @(negedge clk);
        check_outputs_zero("abort_outputs");
        sb_q.delete();
        phy_read = 1'b0;
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        read_check("rx_after_abort", 5'd5, 32'h0);
        read_check("status_after_abort", 5'd1, 32'h0);

        // Fresh read frame, CLKDIV=0, out-of-range bus select falls back to bus 0.
        cfg_write(5'd7, 32'h1);
        cfg_write(5'd2, 32'h0A);
        cfg_write(5'd3, 32'h15);
        cfg_write(5'd4, 32'h0F0F);
        mon_bus  = 0;
        phy_read = 1'b1;
        phy_data = 16'hC3A5;
        start_frame(32'h301, c22_frame(1'b0, 5'h0A, 5'h15, 16'h0), oe_mask(1'b0), 128, 1'b1);
        wait_frames(4);
        phy_read = 1'b0;
        read_check("rx_after_reset", 5'd5, 32'hC3A5);

        // Write frame with the interrupt disabled.
        cfg_write(5'd7, 32'h0);
        cfg_write(5'd4, 32'h8001);
        start_frame(32'h3, c22_frame(1'b1, 5'h0A, 5'h15, 16'h8001), oe_mask(1'b1), 128, 1'b0);
        wait_frames(5);
        check("irq_pulse_count", 64'(irq_cnt), 4);
        check("scoreboard_empty", 64'(sb_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
